// File: rtl/alu_cmd_issuer.sv
// ----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Issue stage in front of the ALU. Commands arrive on a valid/ready port and
// are queued in a small FIFO. One command at a time is driven onto the ALU
// operand/opcode inputs. The block then waits out the ALU's fixed result
// latency, captures C, and offers it on a valid/ready result port.
// Operands and the result pass through unmodified.
//
// Optional feature: define ALU_ISSUER_STATS_EN to enable a saturating 16-bit
// completed-command counter on stat_done_cnt. When the macro is undefined,
// stat_done_cnt is tied to zero.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b               signed operands
//   cmd_a_en, cmd_b_en         ALU enables for this command
//   cmd_a_op, cmd_b_op         ALU opcodes for this command
//   alu_A, alu_B, alu_a_en,
//   alu_b_en, alu_a_op,
//   alu_b_op, alu_en           registered drive to the ALU
//   alu_C                      ALU result input
//   res_valid / res_ready      result handshake
//   res_data                   captured ALU result
//   busy                       FIFO non-empty or a command in progress
//   stat_done_cnt              completed-command count (stats build only)
// ----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int INPUT_WIDTH  = 5,
  parameter int OUTPUT_WIDTH = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int ALU_LATENCY  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic signed [INPUT_WIDTH-1:0]  cmd_a,
  input  logic signed [INPUT_WIDTH-1:0]  cmd_b,
  input  logic                           cmd_a_en,
  input  logic                           cmd_b_en,
  input  logic [2:0]                     cmd_a_op,
  input  logic [1:0]                     cmd_b_op,
  output logic signed [INPUT_WIDTH-1:0]  alu_A,
  output logic signed [INPUT_WIDTH-1:0]  alu_B,
  output logic                           alu_a_en,
  output logic                           alu_b_en,
  output logic [2:0]                     alu_a_op,
  output logic [1:0]                     alu_b_op,
  output logic                           alu_en,
  input  logic signed [OUTPUT_WIDTH-1:0] alu_C,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [OUTPUT_WIDTH-1:0] res_data,
  output logic                           busy,
  output logic [15:0]                    stat_done_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(ALU_LATENCY + 1);
  localparam int CMD_W = 2 * INPUT_WIDTH + 7;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;

  logic [CMD_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic signed [INPUT_WIDTH-1:0] head_a;
  logic signed [INPUT_WIDTH-1:0] head_b;
  logic                          head_a_en;
  logic                          head_b_en;
  logic [2:0]                    head_a_op;
  logic [1:0]                    head_b_op;

  // Ready and busy come from registered state only, so reset shows at once.
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = !fifo_full;
  assign busy       = !fifo_empty || (state != IDLE);

  // A push while full is refused even if a pop frees a slot this cycle.
  assign push = cmd_valid && !fifo_full;
  assign pop  = (state == IDLE) && !fifo_empty;

  assign {head_a, head_b, head_a_en, head_b_en, head_a_op, head_b_op} = fifo_mem[rd_ptr];

  // ---- FIFO storage: data only, never reset ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op};
    end
  end

  // ---- FIFO control: pointers wrap naturally since depth is a power of 2 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---- Issue FSM: launch, wait out ALU latency, hold result until taken ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_a_en  <= 1'b0;
      alu_b_en  <= 1'b0;
      alu_a_op  <= '0;
      alu_b_op  <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_A    <= head_a;
            alu_B    <= head_b;
            alu_a_en <= head_a_en;
            alu_b_en <= head_b_en;
            alu_a_op <= head_a_op;
            alu_b_op <= head_b_op;
            alu_en   <= 1'b1;
            lat_cnt  <= LAT_W'(ALU_LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Count reaches 1 on the edge ALU_LATENCY edges after launch.
          if (lat_cnt == LAT_W'(1)) begin
            res_data  <= alu_C;
            res_valid <= 1'b1;
            alu_en    <= 1'b0;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          alu_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] done_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- Completed-command counter, saturating ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 16'h0000;
    end else if (res_valid && res_ready) begin
      done_cnt <= sat_inc16(done_cnt);
    end
  end

  assign stat_done_cnt = done_cnt;
`else
  assign stat_done_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Bench for alu_cmd_issuer. A behavioural ALU stand-in computes C from the
// driven operands and delivers it through a short register pipeline. Expected
// results are queued when a command is accepted and compared in order when
// the issuer hands a result over.
// ----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

  localparam int IW  = 5;
  localparam int OW  = 6;
  localparam int LAT = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic signed [IW-1:0] cmd_a;
  logic signed [IW-1:0] cmd_b;
  logic                 cmd_a_en;
  logic                 cmd_b_en;
  logic [2:0]           cmd_a_op;
  logic [1:0]           cmd_b_op;
  logic signed [IW-1:0] alu_A;
  logic signed [IW-1:0] alu_B;
  logic                 alu_a_en;
  logic                 alu_b_en;
  logic [2:0]           alu_a_op;
  logic [1:0]           alu_b_op;
  logic                 alu_en;
  logic signed [OW-1:0] alu_C;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [OW-1:0] res_data;
  logic                 busy;
  logic [15:0]          stat_done_cnt;

  int n_vec;
  int n_err;

  logic signed [OW-1:0] sb [$];
  logic signed [OW-1:0] alu_pipe [LAT-1];

  alu_cmd_issuer #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .FIFO_DEPTH  (4),
    .ALU_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_a_en     (cmd_a_en),
    .cmd_b_en     (cmd_b_en),
    .cmd_a_op     (cmd_a_op),
    .cmd_b_op     (cmd_b_op),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_a_en     (alu_a_en),
    .alu_b_en     (alu_b_en),
    .alu_a_op     (alu_a_op),
    .alu_b_op     (alu_b_op),
    .alu_en       (alu_en),
    .alu_C        (alu_C),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .stat_done_cnt(stat_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: operands sign-extended to the result width.
  function automatic logic signed [OW-1:0] alu_f(
    input logic signed [IW-1:0] a,
    input logic signed [IW-1:0] b,
    input logic ae,
    input logic be,
    input logic [2:0] aop,
    input logic [1:0] bop);
    logic signed [OW-1:0] sa;
    logic signed [OW-1:0] sbv;
    logic signed [OW-1:0] r;
    sa  = a;
    sbv = b;
    r   = '0;
    if (ae) begin
      case (aop)
        3'd0:    r = sa + sbv;
        3'd1:    r = sa - sbv;
        3'd2:    r = sa & sbv;
        3'd3:    r = sa | sbv;
        3'd4:    r = sa ^ sbv;
        3'd5:    r = -sa;
        3'd6:    r = sa <<< 1;
        default: r = sbv;
      endcase
    end else if (be) begin
      case (bop)
        2'd0:    r = sbv + 6'sd1;
        2'd1:    r = sbv - 6'sd1;
        2'd2:    r = ~sbv;
        default: r = sa + 6'sd1;
      endcase
    end
    return r;
  endfunction

  // C becomes valid LAT-1 edges after launch and is stable by the capture edge.
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_A, alu_B, alu_a_en, alu_b_en, alu_a_op, alu_b_op);
    for (int i = 1; i < LAT - 1; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_C = alu_pipe[LAT-2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sampled mid-cycle, acts on the upcoming edge's handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", {31'd0, res_valid}, 32'd0);
        end else begin
          check("res_data", res_data, sb.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb.push_back(alu_f(cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op));
      end
    end
  end

  task automatic set_cmd(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b,
                         input logic ae, input logic be,
                         input logic [2:0] aop, input logic [1:0] bop);
    cmd_a    = a;
    cmd_b    = b;
    cmd_a_en = ae;
    cmd_b_en = be;
    cmd_a_op = aop;
    cmd_b_op = bop;
  endtask

  task automatic rand_cmd();
    set_cmd(IW'($urandom), IW'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 2'($urandom));
  endtask

  task automatic push_cmd(input logic signed [IW-1:0] a, input logic signed [IW-1:0] b,
                          input logic ae, input logic be,
                          input logic [2:0] aop, input logic [1:0] bop);
    int k;
    set_cmd(a, b, ae, be, aop, bop);
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) check("push_timeout", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < n) begin
      step();
      k++;
    end
    if (k >= n) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_res_valid(input int n);
    int k;
    k = 0;
    while (!res_valid && k < n) begin
      step();
      k++;
    end
    if (k >= n) check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic signed [OW-1:0] hold_data;
    logic signed [IW-1:0] hold_a;
    logic signed [IW-1:0] ovf_exp;
    logic [15:0]          stat_exp;
    int                   nacc;
    int                   seen;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    set_cmd('0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < LAT - 1; i++) alu_pipe[i] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_stat", {16'd0, stat_done_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single add with latency profile: accept at Ea, pop at Ea+1, result after Ea+4
    res_ready = 1'b1;
    set_cmd(5'sd5, 5'sd3, 1'b1, 1'b0, 3'b000, 2'b00);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("t1_alu_en_ea", {31'd0, alu_en}, 32'd0);
    step();
    check("t1_alu_en_1", {31'd0, alu_en}, 32'd1);
    check("t1_alu_A", alu_A, 32'd5);
    check("t1_alu_B", alu_B, 32'd3);
    check("t1_alu_a_en", {31'd0, alu_a_en}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_alu_en_2", {31'd0, alu_en}, 32'd1);
    step();
    check("t1_alu_en_3", {31'd0, alu_en}, 32'd1);
    check("t1_res_valid_early", {31'd0, res_valid}, 32'd0);
    step();
    check("t1_alu_en_off", {31'd0, alu_en}, 32'd0);
    check("t1_res_valid", {31'd0, res_valid}, 32'd1);
    check("t1_res_data", res_data, 32'd8);
    step();
    check("t1_res_valid_clr", {31'd0, res_valid}, 32'd0);
    wait_idle(50);

    // Overflow extension: -16 + -16 = -32
    push_cmd(-5'sd16, -5'sd16, 1'b1, 1'b0, 3'b000, 2'b00);
    wait_res_valid(20);
    ovf_exp = '0;
    check("ovf_res_data", res_data[OW-1:0], 32'h20);
    wait_idle(50);

    // Fill to capacity, then drain; repeated to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      res_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 7; i++) begin
        rand_cmd();
        cmd_valid = 1'b1;
        @(negedge clk);
        if (cmd_ready) nacc++;
        if (i >= 5) check("fill_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
        step();
      end
      cmd_valid = 1'b0;
      check("fill_accepted", nacc, 32'd5);
      check("fill_busy", {31'd0, busy}, 32'd1);
      res_ready = 1'b1;
      wait_idle(200);
      check("fill_drained", sb.size(), 32'd0);
    end

    // Backpressure: result and ALU drive held while res_ready is low
    res_ready = 1'b0;
    push_cmd(5'sd7, 5'sd2, 1'b1, 1'b0, 3'b001, 2'b00);
    push_cmd(-5'sd3, 5'sd4, 1'b0, 1'b1, 3'b000, 2'b10);
    wait_res_valid(20);
    hold_data = res_data;
    hold_a    = alu_A;
    check("bp_first_A", alu_A, 32'd7);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_data", res_data, hold_data);
      check("bp_alu_A", alu_A, hold_a);
      check("bp_alu_en", {31'd0, alu_en}, 32'd0);
    end
    res_ready = 1'b1;
    step();
    check("bp_rel_res_valid", {31'd0, res_valid}, 32'd0);
    check("bp_rel_alu_en", {31'd0, alu_en}, 32'd0);
    step();
    check("bp_next_pop_en", {31'd0, alu_en}, 32'd1);
    check("bp_next_pop_A", alu_A, -5'sd3);
    wait_idle(50);

    // Random traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      rand_cmd();
      cmd_valid = 1'($urandom);
      res_ready = 1'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(300);

    // Reset in WAIT with commands still queued
    push_cmd(5'sd1, 5'sd1, 1'b1, 1'b0, 3'b000, 2'b00);
    push_cmd(5'sd2, 5'sd2, 1'b1, 1'b0, 3'b000, 2'b00);
    push_cmd(5'sd3, 5'sd3, 1'b1, 1'b0, 3'b000, 2'b00);
    check("rst_mid_in_wait", {31'd0, alu_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_mid_alu_en", {31'd0, alu_en}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_valid || busy) seen++;
    end
    check("rst_no_stale", seen, 32'd0);

    // Completed-command statistics after reset
    push_cmd(5'sd4, 5'sd1, 1'b1, 1'b0, 3'b000, 2'b00);
    push_cmd(5'sd6, 5'sd2, 1'b1, 1'b0, 3'b001, 2'b00);
    push_cmd(-5'sd8, 5'sd5, 1'b0, 1'b1, 3'b000, 2'b01);
    wait_idle(100);
`ifdef ALU_ISSUER_STATS_EN
    stat_exp = 16'd3;
`else
    stat_exp = 16'd0;
`endif
    check("stat_done_cnt", {16'd0, stat_done_cnt}, {16'd0, stat_exp});
    check("end_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("end_sb_empty", sb.size(), 32'd0 + ovf_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
